// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC stream sequencer.
package ecc_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_WAIT = 2'd1,
    E_OUT  = 2'd2
  } enc_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } dec_state_t;

  // Bits needed to index value items (value >= 2 gives at least 1).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/ecc_lat_timer.sv
// Loadable down-counter: done_o is high in the cycle before the edge that
// lies CORE_LAT cycles after the load edge, so the owner samples the core
// result on exactly that edge.
module ecc_lat_timer #(
  parameter int CORE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic done_o
);

  localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CW-1:0] START = CW'(CORE_LAT - 1);

  logic [CW-1:0] cnt_q;
  logic          busy_q;

  assign done_o = busy_q && (cnt_q == '0);

  // Count down from CORE_LAT-1 after a load; stop once done has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= START;
      busy_q <= 1'b1;
    end else if (done_o) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/ecc_stream_ctrl.sv
// ECC encrypt/decrypt sequencer. Encrypt path slices a plaintext word into
// beats for the point-encrypt cores and streams the (x,y) results; decrypt
// path feeds ciphertext beats to the decrypt cores and reassembles words.
// Optional build macro ECC_BLOCK_CNT_EN enables saturating word counters.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid-side data is held stable until that edge, and the
// producer never withdraws valid before the transfer. out_valid is a
// one-cycle pulse with no backpressure.
module ecc_stream_ctrl
  import ecc_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int WORDS    = 2,
  parameter int CORE_LAT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enc_valid,
  output logic                         enc_ready,
  input  logic [8*LANES*WORDS-1:0]     enc_data,
  output logic                         pt_valid,
  input  logic                         pt_ready,
  output logic                         pt_last,
  output logic [8*LANES-1:0]           x_out,
  output logic [8*LANES-1:0]           y_out,
  input  logic                         ct_valid,
  output logic                         ct_ready,
  input  logic [8*LANES-1:0]           x_in,
  input  logic [8*LANES-1:0]           y_in,
  output logic                         out_valid,
  output logic [8*LANES*WORDS-1:0]     data_out,
  output logic [8*LANES-1:0]           enc_core_in,
  input  logic [8*LANES-1:0]           enc_core_x,
  input  logic [8*LANES-1:0]           enc_core_y,
  output logic [8*LANES-1:0]           dec_core_x,
  output logic [8*LANES-1:0]           dec_core_y,
  input  logic [8*LANES-1:0]           dec_core_out,
  output logic [CNT_W-1:0]             enc_blocks,
  output logic [CNT_W-1:0]             dec_blocks
);

  localparam int BEAT_W = BYTE_W * LANES;
  localparam int DW     = BEAT_W * WORDS;
  localparam int BI_W   = clog2(WORDS);
  localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(WORDS - 1);

  // ---------------- encrypt path ----------------
  enc_state_t        enc_state_q;
  logic [DW-1:0]     enc_word_q;
  logic [BI_W-1:0]   enc_beat_q;
  logic [BI_W-1:0]   enc_beat_nx;
  logic [BEAT_W-1:0] enc_core_in_q, x_out_q, y_out_q;
  logic              enc_ready_q, pt_valid_q, pt_last_q;
  logic              enc_accept, pt_fire, enc_tmr_load, enc_tmr_done;

  assign enc_accept   = enc_valid && enc_ready_q;
  assign pt_fire      = (enc_state_q == E_OUT) && pt_ready;
  assign enc_tmr_load = enc_accept || (pt_fire && !pt_last_q);
  assign enc_beat_nx  = enc_beat_q + BI_W'(1);

  ecc_lat_timer #(.CORE_LAT(CORE_LAT)) u_enc_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (enc_tmr_load),
    .done_o (enc_tmr_done)
  );

  // Encrypt FSM: accept a word, then per beat wait for the core and stream it.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_state_q   <= E_IDLE;
      enc_word_q    <= '0;
      enc_beat_q    <= '0;
      enc_core_in_q <= '0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      enc_ready_q   <= 1'b1;
      pt_valid_q    <= 1'b0;
      pt_last_q     <= 1'b0;
    end else begin
      case (enc_state_q)
        E_IDLE: begin
          if (enc_accept) begin
            enc_word_q    <= enc_data;
            enc_core_in_q <= enc_data[BEAT_W-1:0];
            enc_beat_q    <= '0;
            enc_ready_q   <= 1'b0;
            enc_state_q   <= E_WAIT;
          end
        end
        E_WAIT: begin
          if (enc_tmr_done) begin
            x_out_q     <= enc_core_x;
            y_out_q     <= enc_core_y;
            pt_valid_q  <= 1'b1;
            pt_last_q   <= (enc_beat_q == LAST_BEAT);
            enc_state_q <= E_OUT;
          end
        end
        E_OUT: begin
          if (pt_ready) begin
            pt_valid_q <= 1'b0;
            if (pt_last_q) begin
              pt_last_q   <= 1'b0;
              enc_ready_q <= 1'b1;
              enc_state_q <= E_IDLE;
            end else begin
              enc_beat_q    <= enc_beat_nx;
              enc_core_in_q <= enc_word_q[int'(enc_beat_nx)*BEAT_W +: BEAT_W];
              enc_state_q   <= E_WAIT;
            end
          end
        end
        default: enc_state_q <= E_IDLE;
      endcase
    end
  end

  assign enc_ready   = enc_ready_q;
  assign pt_valid    = pt_valid_q;
  assign pt_last     = pt_last_q;
  assign x_out       = x_out_q;
  assign y_out       = y_out_q;
  assign enc_core_in = enc_core_in_q;

  // ---------------- decrypt path ----------------
  dec_state_t        dec_state_q;
  logic [BI_W-1:0]   dec_beat_q;
  logic [DW-1:0]     asm_q, asm_d, data_out_q;
  logic [BEAT_W-1:0] dec_core_x_q, dec_core_y_q;
  logic              ct_ready_q, out_valid_q;
  logic              dec_tmr_load, dec_tmr_done;

  assign dec_tmr_load = ct_valid && ct_ready_q;

  ecc_lat_timer #(.CORE_LAT(CORE_LAT)) u_dec_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (dec_tmr_load),
    .done_o (dec_tmr_done)
  );

  // Assembly buffer with the current core result dropped into its slot.
  always_comb begin
    asm_d = asm_q;
    asm_d[int'(dec_beat_q)*BEAT_W +: BEAT_W] = dec_core_out;
  end

  // Decrypt FSM: one beat in flight; the last beat publishes the whole word.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state_q  <= D_IDLE;
      dec_beat_q   <= '0;
      asm_q        <= '0;
      data_out_q   <= '0;
      dec_core_x_q <= '0;
      dec_core_y_q <= '0;
      ct_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (dec_state_q)
        D_IDLE: begin
          if (dec_tmr_load) begin
            dec_core_x_q <= x_in;
            dec_core_y_q <= y_in;
            ct_ready_q   <= 1'b0;
            dec_state_q  <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (dec_tmr_done) begin
            asm_q <= asm_d;
            if (dec_beat_q == LAST_BEAT) begin
              data_out_q  <= asm_d;
              out_valid_q <= 1'b1;
              dec_beat_q  <= '0;
            end else begin
              dec_beat_q <= dec_beat_q + BI_W'(1);
            end
            ct_ready_q  <= 1'b1;
            dec_state_q <= D_IDLE;
          end
        end
        default: dec_state_q <= D_IDLE;
      endcase
    end
  end

  assign ct_ready   = ct_ready_q;
  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign dec_core_x = dec_core_x_q;
  assign dec_core_y = dec_core_y_q;

  // ---------------- completed-word counters ----------------
`ifdef ECC_BLOCK_CNT_EN
  logic [CNT_W-1:0] enc_blocks_q, dec_blocks_q;

  // Saturating counts of fully streamed and fully reassembled words.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_blocks_q <= '0;
      dec_blocks_q <= '0;
    end else begin
      if (pt_fire && pt_last_q && (enc_blocks_q != '1))
        enc_blocks_q <= enc_blocks_q + CNT_W'(1);
      if (out_valid_q && (dec_blocks_q != '1))
        dec_blocks_q <= dec_blocks_q + CNT_W'(1);
    end
  end

  assign enc_blocks = enc_blocks_q;
  assign dec_blocks = dec_blocks_q;
`else
  assign enc_blocks = '0;
  assign dec_blocks = '0;
`endif

endmodule
